// File: rtl/tone_poly_pkg.sv
// tone_poly_pkg: note frequencies, rest code and elaboration-time helpers for the tone generator.
// Latency: none; holds constants and functions that are evaluated at elaboration only.
// Backpressure: none.
package tone_poly_pkg;

    // C4, D4, E4, F4, G4, A4, B4, C5 in Hz
    localparam int unsigned NOTE_FREQ [8] = '{261, 293, 329, 349, 392, 440, 493, 523};

    // Note codes at or above this value are rests
    localparam logic [3:0] NOTE_REST = 4'd8;

    // Half period in clocks, rounded to nearest (the +f term does the rounding)
    function automatic int unsigned note_half(input int unsigned clk_hz, input logic [2:0] idx);
        return (clk_hz + NOTE_FREQ[idx]) / (2 * NOTE_FREQ[idx]);
    endfunction

    // Clocks per millisecond
    function automatic int unsigned ms_div(input int unsigned clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/tone_voice.sv
// tone_voice: one square-wave voice with half-period phase counter and millisecond duration counter.
// Latency: busy rises the cycle after load; done pulses one cycle after the final ms tick (or after one busy cycle for zero length).
// Backpressure: load must only be asserted while busy is low; the parent gates it with busy.
module tone_voice
    import tone_poly_pkg::*;
#(
    parameter int unsigned CNT_W = 17,
    parameter int unsigned DUR_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ms_tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_half,
    input  logic             load_rest,
    input  logic [DUR_W-1:0] load_dur,
    output logic             tone_out,
    output logic             busy,
    output logic             done
);

    logic [CNT_W-1:0] phase_q, phase_d;
    logic [CNT_W-1:0] half_q,  half_d;
    logic [DUR_W-1:0] rem_q,   rem_d;
    logic             rest_q,  rest_d;
    logic             busy_q,  busy_d;
    logic             tone_q,  tone_d;
    logic             done_q,  done_d;

    // Next state: load a note, finish it, or advance the phase and duration counters
    always_comb begin
        phase_d = phase_q;
        half_d  = half_q;
        rem_d   = rem_q;
        rest_d  = rest_q;
        busy_d  = busy_q;
        tone_d  = tone_q;
        done_d  = 1'b0;
        if (load) begin
            half_d  = load_half;
            rem_d   = load_dur;
            rest_d  = load_rest;
            phase_d = '0;
            tone_d  = 1'b0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            // Zero length finishes after a single busy cycle; otherwise the tick seen at rem=1 ends it
            if ((rem_q == '0) || (ms_tick && (rem_q == DUR_W'(1)))) begin
                busy_d  = 1'b0;
                tone_d  = 1'b0;
                done_d  = 1'b1;
                phase_d = '0;
            end else begin
                if (ms_tick) begin
                    rem_d = rem_q - 1'b1;
                end
                if (!rest_q) begin
                    if (phase_q == half_q - 1'b1) begin
                        phase_d = '0;
                        tone_d  = ~tone_q;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
        end
    end

    // Voice state registers; reset aborts any note without a done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= '0;
            half_q  <= '0;
            rem_q   <= '0;
            rest_q  <= 1'b0;
            busy_q  <= 1'b0;
            tone_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            half_q  <= half_d;
            rem_q   <= rem_d;
            rest_q  <= rest_d;
            busy_q  <= busy_d;
            tone_q  <= tone_d;
            done_q  <= done_d;
        end
    end

    assign tone_out = tone_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: rtl/tone_poly_gen.sv
// tone_poly_gen: NUM_CH-voice square-wave note player with shared ms prescaler; optional mix via TONE_POLY_MIX_EN.
// Latency: accepted command shows busy next cycle; mix_out is one registered cycle behind tone_out.
// Backpressure: cmd_ready = ~busy of the selected voice; a stalled command has no side effects.
module tone_poly_gen
    import tone_poly_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 17,
    parameter int unsigned DUR_W  = 16,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk1,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CH_W-1:0]   cmd_ch,
    input  logic [3:0]        cmd_note,
    input  logic [DUR_W-1:0]  cmd_dur_ms,
    output logic [NUM_CH-1:0] tone_out,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic              mix_out,
    output logic              ground
);

    localparam int unsigned MS_DIV = ms_div(CLK_HZ);
    localparam int unsigned PS_W   = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

    logic [PS_W-1:0]  ps_q, ps_d;
    logic             ms_tick;
    logic             accept;
    logic [CNT_W-1:0] half_tbl [8];
    logic [CNT_W-1:0] load_half;
    logic             load_rest;

    // Free-running millisecond prescaler; ms_tick marks the wrap cycle
    always_comb begin
        ms_tick = (ps_q == PS_W'(MS_DIV - 1));
        ps_d    = ms_tick ? '0 : ps_q + 1'b1;
    end

    // Prescaler register
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            ps_q <= '0;
        end else begin
            ps_q <= ps_d;
        end
    end

    // Half-period table fixed at elaboration from the clock frequency
    for (genvar n = 0; n < 8; n++) begin : g_tbl
        localparam int unsigned HALF = note_half(CLK_HZ, 3'(n));
        assign half_tbl[n] = CNT_W'(HALF);
    end

    // Command decode; a channel index beyond NUM_CH is never accepted
    always_comb begin
        cmd_ready = 1'b0;
        if (32'(cmd_ch) < NUM_CH) begin
            cmd_ready = ~busy[cmd_ch];
        end
        accept    = cmd_valid & cmd_ready;
        load_half = half_tbl[cmd_note[2:0]];
        load_rest = (cmd_note >= NOTE_REST);
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_voice
        tone_voice #(
            .CNT_W (CNT_W),
            .DUR_W (DUR_W)
        ) u_voice (
            .clk       (clk1),
            .rst_n     (reset),
            .ms_tick   (ms_tick),
            .load      (accept && (cmd_ch == CH_W'(i))),
            .load_half (load_half),
            .load_rest (load_rest),
            .load_dur  (cmd_dur_ms),
            .tone_out  (tone_out[i]),
            .busy      (busy[i]),
            .done      (done[i])
        );
    end

`ifdef TONE_POLY_MIX_EN
    localparam int unsigned ACC_W = $clog2(NUM_CH) + 2;

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] pop;
    logic [ACC_W-1:0] sum;
    logic             mix_q, mix_d;

    // First-order delta-sigma of the number of voices currently high
    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop = pop + ACC_W'(tone_out[i]);
        end
        sum   = acc_q + pop;
        acc_d = sum;
        mix_d = 1'b0;
        if (sum >= ACC_W'(NUM_CH)) begin
            acc_d = sum - ACC_W'(NUM_CH);
            mix_d = 1'b1;
        end
    end

    // Mixer accumulator and registered 1-bit output
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
            mix_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            mix_q <= mix_d;
        end
    end

    assign mix_out = mix_q;
`else
    assign mix_out = 1'b0;
`endif

    assign ground = 1'b0;

endmodule

// File: tb/tb_tone_poly_gen.sv
// tb_tone_poly_gen: directed and random note commands checked against an arithmetic model of each voice.
// Latency: model predicts outputs sampled on the falling edge after each rising edge.
// Backpressure: model decides acceptance from its own busy prediction.
module tb_tone_poly_gen;

    localparam int unsigned CLK_HZ = 1_000_000;
    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CNT_W  = 17;
    localparam int unsigned DUR_W  = 16;
    localparam int          MS     = 1000;
    localparam int          FREQ [8] = '{261, 293, 329, 349, 392, 440, 493, 523};

    logic             clk1       = 1'b0;
    logic             reset      = 1'b0;
    logic             cmd_valid  = 1'b0;
    logic [1:0]       cmd_ch     = 2'd0;
    logic [3:0]       cmd_note   = 4'd0;
    logic [DUR_W-1:0] cmd_dur_ms = '0;
    logic             cmd_ready;
    logic [3:0]       tone_out;
    logic [3:0]       busy;
    logic [3:0]       done;
    logic             mix_out;
    logic             ground;

    int n_chk  = 0;
    int n_fail = 0;
    int n_edge = 0;

    // Model: per voice, the accept edge, duration, half period and rest flag
    bit m_on   [4];
    int m_k    [4];
    int m_dur  [4];
    int m_half [4];
    bit m_rest [4];

    always #5 clk1 = ~clk1;

    tone_poly_gen #(
        .CLK_HZ (CLK_HZ),
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .DUR_W  (DUR_W)
    ) dut (
        .clk1       (clk1),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_ch     (cmd_ch),
        .cmd_note   (cmd_note),
        .cmd_dur_ms (cmd_dur_ms),
        .tone_out   (tone_out),
        .busy       (busy),
        .done       (done),
        .mix_out    (mix_out),
        .ground     (ground)
    );

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            m_on[c]   = 1'b0;
            m_k[c]    = 0;
            m_dur[c]  = 0;
            m_half[c] = 1;
            m_rest[c] = 1'b0;
        end
    endtask

    // Edge on which the voice finishes: the dur-th ms boundary after the accept edge
    function automatic int m_end(int c);
        if (m_dur[c] == 0) return m_k[c] + 1;
        return (m_k[c] / MS + m_dur[c]) * MS;
    endfunction

    function automatic logic [3:0] m_busy_v();
        logic [3:0] v;
        v = '0;
        for (int c = 0; c < 4; c++)
            v[c] = m_on[c] && (n_edge >= m_k[c]) && (n_edge < m_end(c));
        return v;
    endfunction

    // Expected {tone_out, busy, done, cmd_ready}
    function automatic logic [12:0] m_expect();
        logic [3:0] b, t, d;
        b = m_busy_v();
        t = '0;
        d = '0;
        for (int c = 0; c < 4; c++) begin
            d[c] = m_on[c] && (n_edge == m_end(c));
            t[c] = b[c] && !m_rest[c] && ((((n_edge - m_k[c]) / m_half[c]) % 2) == 1);
        end
        return {t, b, d, !b[cmd_ch]};
    endfunction

    // One clock: advance the edge count and record an accept the model predicts
    task automatic cycle();
        logic [3:0] b;
        bit take;
        int c, dur, half;
        bit rest;
        b    = m_busy_v();
        c    = int'(cmd_ch);
        take = cmd_valid && !b[c];
        dur  = int'(cmd_dur_ms);
        rest = (cmd_note >= 4'd8);
        half = (int'(CLK_HZ) + FREQ[cmd_note[2:0]]) / (2 * FREQ[cmd_note[2:0]]);
        @(posedge clk1);
        n_edge++;
        if (take) begin
            m_on[c]   = 1'b1;
            m_k[c]    = n_edge;
            m_dur[c]  = dur;
            m_rest[c] = rest;
            m_half[c] = half;
        end
        @(negedge clk1);
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_ch     = 2'd0;
        cmd_note   = 4'd5;
        cmd_dur_ms = 16'd5;
        repeat (4) begin
            @(negedge clk1);
            n_chk++;
            if ({tone_out, busy, done, mix_out, ground} !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_outputs: got tone/busy/done/mix/gnd=%b required all 0",
                         {tone_out, busy, done, mix_out, ground});
            end
        end
        cmd_valid = 1'b0;
        reset     = 1'b1;
        n_edge    = 0;
        model_clear();
        #1;
        n_chk++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b required 1", cmd_ready);
        end
    endtask

    task automatic test_single_note();
        int  busy_cnt = 0, done_cnt = 0, tog_cnt = 0, bad_iv = 0, last_tog;
        bit  bad = 1'b0;
        logic prev;
        logic [12:0] e;
        repeat ($urandom_range(0, 999)) cycle();
        cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_note = 4'd5; cmd_dur_ms = 16'd5;
        cycle();
        cmd_valid = 1'b0;
        last_tog  = n_edge;
        prev      = 1'b0;
        repeat (5010) begin
            e = m_expect();
            if (!bad) begin
                n_chk++;
                if ({tone_out, busy, done, cmd_ready} !== e) begin
                    n_fail++; bad = 1'b1;
                    $display("FAIL single_note edge %0d: got tone/busy/done/rdy=%b required %b",
                             n_edge, {tone_out, busy, done, cmd_ready}, e);
                end
            end
            if (busy[0]) busy_cnt++;
            if (done[0]) done_cnt++;
            if (busy[0] && (tone_out[0] !== prev)) begin
                if (n_edge - last_tog != 1136) bad_iv++;
                last_tog = n_edge;
                tog_cnt++;
            end
            prev = tone_out[0];
            cycle();
        end
        n_chk++;
        if (busy_cnt < 4001 || busy_cnt > 5000) begin
            n_fail++;
            $display("FAIL single_note_busy_len: got %0d cycles required 4001..5000", busy_cnt);
        end
        n_chk++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL single_note_done_count: got %0d required 1", done_cnt);
        end
        n_chk++;
        if (tog_cnt < 3 || bad_iv != 0) begin
            n_fail++;
            $display("FAIL single_note_half_period: got %0d toggles with %0d not 1136 apart, required >=3 all 1136",
                     tog_cnt, bad_iv);
        end
    endtask

    task automatic test_two_voices();
        int k1, t1 = -1, t2 = -1, rise1 = -1;
        bit tone2_hi = 1'b0, bad = 1'b0;
        logic [12:0] e;
        cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_note = 4'd0; cmd_dur_ms = 16'd3;
        cycle();
        k1 = n_edge;
        cmd_ch = 2'd2; cmd_note = 4'(8 + $urandom_range(0, 7)); cmd_dur_ms = 16'd2;
        cycle();
        cmd_valid = 1'b0;
        repeat (3100) begin
            e = m_expect();
            if (!bad) begin
                n_chk++;
                if ({tone_out, busy, done, cmd_ready} !== e) begin
                    n_fail++; bad = 1'b1;
                    $display("FAIL two_voices edge %0d: got tone/busy/done/rdy=%b required %b",
                             n_edge, {tone_out, busy, done, cmd_ready}, e);
                end
            end
            if (done[1] && t1 < 0) t1 = n_edge;
            if (done[2] && t2 < 0) t2 = n_edge;
            if (tone_out[2]) tone2_hi = 1'b1;
            if (tone_out[1] && rise1 < 0) rise1 = n_edge;
            cycle();
        end
        n_chk++;
        if (t1 < 0 || t2 < 0 || t2 >= t1) begin
            n_fail++;
            $display("FAIL two_voices_done_order: got done2 at %0d done1 at %0d required both seen with done2 first", t2, t1);
        end
        n_chk++;
        if (tone2_hi) begin
            n_fail++;
            $display("FAIL rest_silent: got tone_out[2]=1 required 0 throughout");
        end
        n_chk++;
        if (rise1 - k1 != 1916) begin
            n_fail++;
            $display("FAIL c4_half_period: got first rise %0d cycles after accept required 1916", rise1 - k1);
        end
    endtask

    task automatic test_busy_stall();
        bit took = 1'b0, bad = 1'b0;
        logic [3:0]  b;
        logic [12:0] e;
        cmd_valid = 1'b1; cmd_ch = 2'd1; cmd_note = 4'($urandom_range(0, 7)); cmd_dur_ms = 16'd2;
        cycle();
        cmd_note   = 4'($urandom_range(0, 15));
        cmd_dur_ms = 16'($urandom_range(1, 2));
        for (int i = 0; i < 2100 && !took; i++) begin
            b = m_busy_v();
            e = m_expect();
            if (!bad) begin
                n_chk++;
                if ({tone_out, busy, done, cmd_ready} !== e) begin
                    n_fail++; bad = 1'b1;
                    $display("FAIL busy_stall edge %0d: got tone/busy/done/rdy=%b required %b",
                             n_edge, {tone_out, busy, done, cmd_ready}, e);
                end
            end
            if (!b[1]) begin
                n_chk++;
                if (done[1] !== 1'b1 || cmd_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stall_release: got done1=%b rdy=%b required 1 1", done[1], cmd_ready);
                end
                took = 1'b1;
            end
            cycle();
        end
        cmd_valid = 1'b0;
        n_chk++;
        if (!took) begin
            n_fail++;
            $display("FAIL stall_timeout: got no release within 2100 cycles required release");
        end
        n_chk++;
        if (busy[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_accept: got busy1=%b required 1", busy[1]);
        end
        bad = 1'b0;
        repeat (2100) begin
            e = m_expect();
            if (!bad) begin
                n_chk++;
                if ({tone_out, busy, done, cmd_ready} !== e) begin
                    n_fail++; bad = 1'b1;
                    $display("FAIL stall_second_note edge %0d: got tone/busy/done/rdy=%b required %b",
                             n_edge, {tone_out, busy, done, cmd_ready}, e);
                end
            end
            cycle();
        end
    endtask

    task automatic test_zero_dur();
        bit tone_hi = 1'b0;
        cmd_valid = 1'b1; cmd_ch = 2'd3; cmd_note = 4'($urandom_range(0, 7)); cmd_dur_ms = 16'd0;
        cycle();
        cmd_valid = 1'b0;
        tone_hi = tone_hi | tone_out[3];
        n_chk++;
        if (busy[3] !== 1'b1 || done[3] !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_dur_busy: got busy3=%b done3=%b required 1 0", busy[3], done[3]);
        end
        cycle();
        tone_hi = tone_hi | tone_out[3];
        n_chk++;
        if (busy[3] !== 1'b0 || done[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_dur_done: got busy3=%b done3=%b required 0 1", busy[3], done[3]);
        end
        cycle();
        tone_hi = tone_hi | tone_out[3];
        n_chk++;
        if (done[3] !== 1'b0 || tone_hi) begin
            n_fail++;
            $display("FAIL zero_dur_after: got done3=%b tone_seen=%b required 0 0", done[3], tone_hi);
        end
    endtask

    task automatic test_back_to_back();
        bit bad = 1'b0, bad_mix = 1'b0, will;
        int pop_sum = 0, mix_ones = 0;
        logic [3:0]  b;
        logic [12:0] e;
        repeat (12000) begin
            e = m_expect();
            if (!bad) begin
                n_chk++;
                if ({tone_out, busy, done, cmd_ready} !== e) begin
                    n_fail++; bad = 1'b1;
                    $display("FAIL random edge %0d: got tone/busy/done/rdy=%b required %b",
                             n_edge, {tone_out, busy, done, cmd_ready}, e);
                end
            end
`ifndef TONE_POLY_MIX_EN
            if (!bad_mix) begin
                n_chk++;
                if (mix_out !== 1'b0) begin
                    n_fail++; bad_mix = 1'b1;
                    $display("FAIL mix_disabled edge %0d: got %b required 0", n_edge, mix_out);
                end
            end
`endif
            pop_sum  += $countones(tone_out);
            mix_ones += int'(mix_out);
            if (!cmd_valid && $urandom_range(0, 39) == 0) begin
                cmd_valid  = 1'b1;
                cmd_ch     = 2'($urandom_range(0, 3));
                cmd_note   = 4'($urandom_range(0, 15));
                cmd_dur_ms = 16'($urandom_range(0, 3));
            end
            b    = m_busy_v();
            will = cmd_valid && !b[cmd_ch];
            cycle();
            if (will) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        repeat (3100) begin
            e = m_expect();
            if (!bad) begin
                n_chk++;
                if ({tone_out, busy, done, cmd_ready} !== e) begin
                    n_fail++; bad = 1'b1;
                    $display("FAIL random_drain edge %0d: got tone/busy/done/rdy=%b required %b",
                             n_edge, {tone_out, busy, done, cmd_ready}, e);
                end
            end
            cycle();
        end
`ifdef TONE_POLY_MIX_EN
        n_chk++;
        if (mix_ones * 4 - pop_sum > 8 || pop_sum - mix_ones * 4 > 8) begin
            n_fail++;
            $display("FAIL mix_density: got %0d ones for popcount sum %0d required sum/4 within 2",
                     mix_ones, pop_sum);
        end
`endif
    endtask

    task automatic test_reset_mid_note();
        bit bad = 1'b0;
        logic [12:0] e;
        cmd_valid = 1'b1; cmd_ch = 2'd0; cmd_note = 4'd5; cmd_dur_ms = 16'd3;
        cycle();
        cmd_valid = 1'b0;
        repeat (1200) begin
            e = m_expect();
            if (!bad) begin
                n_chk++;
                if ({tone_out, busy, done, cmd_ready} !== e) begin
                    n_fail++; bad = 1'b1;
                    $display("FAIL mid_note_play edge %0d: got tone/busy/done/rdy=%b required %b",
                             n_edge, {tone_out, busy, done, cmd_ready}, e);
                end
            end
            cycle();
        end
        n_chk++;
        if (tone_out[0] !== 1'b1 || busy[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_note_setup: got tone0=%b busy0=%b required 1 1", tone_out[0], busy[0]);
        end
        @(posedge clk1);
        #2 reset = 1'b0;
        #1;
        n_chk++;
        if (tone_out !== 4'd0 || busy !== 4'd0 || done !== 4'd0) begin
            n_fail++;
            $display("FAIL async_abort: got tone=%b busy=%b done=%b required 0 0 0", tone_out, busy, done);
        end
        repeat (3) begin
            @(negedge clk1);
            n_chk++;
            if (done !== 4'd0 || busy !== 4'd0) begin
                n_fail++;
                $display("FAIL abort_no_done: got done=%b busy=%b required 0 0", done, busy);
            end
        end
        reset  = 1'b1;
        n_edge = 0;
        model_clear();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_note();
        test_two_voices();
        test_busy_stall();
        test_zero_dur();
        test_back_to_back();
        test_reset_mid_note();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
